// File: rtl/finn_stream_pkg.sv
// Shared definitions for the FINN-style AXI-Stream stages: width helpers,
// converter legality check and common handshake levels.
package finn_stream_pkg;

    // Handshake levels shared by the stream stages.
    localparam logic AXIS_ASSERTED     = 1'b1;
    localparam logic AXIS_DEASSERTED   = 1'b0;
    localparam logic AXIS_READY_IN_RST = AXIS_DEASSERTED;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A down-converter is legal only when the wide word splits into whole slices.
    function automatic bit dwc_ratio_ok(input int wide_w, input int narrow_w);
        return (narrow_w > 0) && (wide_w >= narrow_w) && ((wide_w % narrow_w) == 0);
    endfunction

    // Slice index width; a ratio of 1 still needs a 1-bit (constant zero) index.
    function automatic int dwc_idx_width(input int ratio);
        return (ratio > 1) ? clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/streaming_dwc_down.sv
// AXI-Stream down-converter: each IN_WIDTH word leaves as RATIO OUT_WIDTH
// slices, least-significant slice first, with no bubbles between words.
module streaming_dwc_down
    import finn_stream_pkg::*;
#(
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 64
) (
    input  logic                                   ap_clk,
    input  logic                                   ap_rst_n,
    input  logic [IN_WIDTH-1:0]                    in0_V_V_TDATA,
    input  logic                                   in0_V_V_TVALID,
    output logic                                   in0_V_V_TREADY,
    output logic [OUT_WIDTH-1:0]                   out_V_V_TDATA,
    output logic                                   out_V_V_TVALID,
    input  logic                                   out_V_V_TREADY,
    output logic [clog2(IN_WIDTH/OUT_WIDTH):0]     occupancy
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = dwc_idx_width(RATIO);
    localparam int OCC_W = clog2(RATIO) + 1;

    if (!dwc_ratio_ok(IN_WIDTH, OUT_WIDTH) || (RATIO < 1)) begin : g_bad_ratio
        $error("streaming_dwc_down: IN_WIDTH must be a positive multiple of OUT_WIDTH");
    end

    logic [IN_WIDTH-1:0] word_buf;
    logic [IDX_W-1:0]    idx;
    logic                full;
    logic                last_slice;
    logic                in_hs;
    logic                out_hs;

    assign last_slice = (idx == IDX_W'(RATIO - 1));
    assign in_hs      = in0_V_V_TVALID && in0_V_V_TREADY;
    assign out_hs     = full && out_V_V_TREADY;

    // A new word can only land while the buffer is empty or its last slice
    // is leaving this cycle, so the load branch also covers the overlap case.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            word_buf <= '0;
            idx      <= '0;
            full     <= AXIS_DEASSERTED;
        end else if (in_hs) begin
            word_buf <= in0_V_V_TDATA;
            idx      <= '0;
            full     <= AXIS_ASSERTED;
        end else if (out_hs) begin
            if (last_slice) begin
                full <= AXIS_DEASSERTED;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Ready is combinational from the sink so consecutive words run gap-free.
    assign in0_V_V_TREADY = ap_rst_n ? (!full || (last_slice && out_V_V_TREADY))
                                     : AXIS_READY_IN_RST;

    assign out_V_V_TVALID = full;
    assign out_V_V_TDATA  = word_buf[int'(idx) * OUT_WIDTH +: OUT_WIDTH];
    assign occupancy      = full ? (OCC_W'(RATIO) - OCC_W'(idx)) : '0;

endmodule
